// File: rtl/btn_cond.sv
// Push-button conditioner: 2-flop synchronizer, per-bit debounce, press pulse
// and tick-paced auto-repeat advance pulse for each of NB independent buttons.
module btn_cond #(
    parameter int NB      = 5,
    parameter int DB      = 4,
    parameter int RPT_DLY = 3,
    parameter int RPT_PER = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [NB-1:0] btn_raw,
    input  logic          tick,
    output logic [NB-1:0] btn_lvl,
    output logic [NB-1:0] btn_rise,
    output logic [NB-1:0] btn_adv
);

    localparam int RMAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int RW   = $clog2(RMAX + 1);
    localparam int DW   = $clog2(DB + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_REPEAT,
        S_HOLD
    } state_t;

    logic [NB-1:0] r_s1, r_s2;
    logic [NB-1:0] r_lvl, r_rise, r_adv;
    logic [DW-1:0] r_dcnt [NB];
    logic [RW-1:0] r_rcnt [NB];
    state_t        r_state [NB];

    logic [NB-1:0] w_flip, w_rise_ev, w_fall_ev, w_adv_nxt;
    logic [RW-1:0] w_rcnt_nxt [NB];
    state_t        w_state_nxt [NB];

    // Level flips on the DB-th consecutive synced cycle that disagrees with it
    always_comb begin
        for (int unsigned i = 0; i < NB; i++) begin
            w_flip[i] = (r_s2[i] != r_lvl[i]) && (r_dcnt[i] == DW'(DB - 1));
        end
    end

    assign w_rise_ev = w_flip & ~r_lvl;
    assign w_fall_ev = w_flip & r_lvl;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_lvl  <= '0;
            r_rise <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                r_dcnt[i] <= '0;
            end
        end else begin
            r_s1   <= btn_raw;
            r_s2   <= r_s1;
            r_lvl  <= r_lvl ^ w_flip;
            r_rise <= w_rise_ev;
            for (int unsigned i = 0; i < NB; i++) begin
                if ((r_s2[i] == r_lvl[i]) || w_flip[i]) begin
                    r_dcnt[i] <= '0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + DW'(1);
                end
            end
        end
    end

    // Ticks are ignored both on the press edge and while the rise pulse is out
    always_comb begin
        for (int unsigned i = 0; i < NB; i++) begin
            w_state_nxt[i] = r_state[i];
            w_rcnt_nxt[i]  = r_rcnt[i];
            w_adv_nxt[i]   = 1'b0;
            case (r_state[i])
                S_IDLE: begin
                    if (w_rise_ev[i]) begin
                        w_state_nxt[i] = S_DELAY;
                        w_rcnt_nxt[i]  = '0;
                        w_adv_nxt[i]   = 1'b1;
                    end
                end
                S_DELAY: begin
                    if (tick && !r_rise[i]) begin
                        if (r_rcnt[i] + RW'(1) == RW'(RPT_DLY)) begin
                            w_adv_nxt[i]   = 1'b1;
                            w_rcnt_nxt[i]  = '0;
                            w_state_nxt[i] = (RPT_PER == 0) ? S_HOLD : S_REPEAT;
                        end else begin
                            w_rcnt_nxt[i] = r_rcnt[i] + RW'(1);
                        end
                    end
                end
                S_REPEAT: begin
                    if (tick && !r_rise[i]) begin
                        if (r_rcnt[i] + RW'(1) == RW'(RPT_PER)) begin
                            w_adv_nxt[i]  = 1'b1;
                            w_rcnt_nxt[i] = '0;
                        end else begin
                            w_rcnt_nxt[i] = r_rcnt[i] + RW'(1);
                        end
                    end
                end
                default: ;
            endcase
            if (w_fall_ev[i]) begin
                w_state_nxt[i] = S_IDLE;
                w_rcnt_nxt[i]  = '0;
                w_adv_nxt[i]   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_adv <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                r_state[i] <= S_IDLE;
                r_rcnt[i]  <= '0;
            end
        end else begin
            r_adv <= w_adv_nxt;
            for (int unsigned i = 0; i < NB; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_rcnt[i]  <= w_rcnt_nxt[i];
            end
        end
    end

    assign btn_lvl  = r_lvl;
    assign btn_rise = r_rise;
    assign btn_adv  = r_adv;

endmodule
